// File: rtl/coin_classifier.sv
// Coin classifier: times how long the synchronised coin sensor stays high and matches the
// duration against per-coin [min,max] windows. Optional credit accumulator under COIN_CREDIT_EN.
module coin_classifier #(
    parameter int NUM_COINS = 3,
    parameter int TIME_W = 21,
    parameter int SYNC_STAGES = 2,
    parameter logic [NUM_COINS*TIME_W-1:0] MIN_TIMES = {21'd580000, 21'd480000, 21'd380000},
    parameter logic [NUM_COINS*TIME_W-1:0] MAX_TIMES = {21'd620000, 21'd520000, 21'd420000},
    parameter int MIN_PULSE = 16,
    parameter int OVERSIZE_LIMIT = 1000000,
    parameter int CREDIT_W = 16,
    parameter logic [NUM_COINS*8-1:0] COIN_VALUES = {8'd25, 8'd5, 8'd10},
    localparam int ID_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_sensor,
    input  logic                clear_credit,
    output logic                coin_valid,
    output logic [ID_W-1:0]     coin_id,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    // state    | meaning
    // IDLE     | waiting for the sensor to go high
    // MEASURE  | sensor high, counting duration
    // CLASSIFY | one cycle: compare duration against the windows
    // OVERSIZE | duration hit the limit, waiting for the sensor to clear
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MEASURE  = 2'd1;
    localparam logic [1:0] CLASSIFY = 2'd2;
    localparam logic [1:0] OVERSIZE = 2'd3;

    localparam logic [TIME_W-1:0] MIN_PULSE_T = TIME_W'(MIN_PULSE);
    localparam logic [TIME_W-1:0] OVERSIZE_T  = TIME_W'(OVERSIZE_LIMIT);

    logic [SYNC_STAGES-1:0] syncReg;
    logic                   sensorS;
    logic [1:0]             state;
    logic [TIME_W-1:0]      count;
    logic [TIME_W-1:0]      countNext;
    logic                   matchFound;
    logic [ID_W-1:0]        matchId;
    logic                   longEnough;

    always_ff @(posedge clk) begin
        if (reset) begin
            syncReg <= '0;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], coin_sensor};
        end
    end

    assign sensorS    = syncReg[SYNC_STAGES-1];
    assign countNext  = count + TIME_W'(1);
    assign longEnough = (count >= MIN_PULSE_T);
    assign busy       = (state != IDLE);

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        matchFound = 1'b0;
        matchId    = '0;
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if ((count >= MIN_TIMES[i*TIME_W +: TIME_W]) &&
                (count <= MAX_TIMES[i*TIME_W +: TIME_W])) begin
                matchFound = 1'b1;
                matchId    = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            coin_valid  <= 1'b0;
            coin_reject <= 1'b0;
            coin_id     <= '0;
        end else begin
            coin_valid  <= 1'b0;
            coin_reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (sensorS) begin
                        state <= MEASURE;
                        count <= TIME_W'(1);
                    end
                end
                MEASURE: begin
                    if (sensorS) begin
                        count <= countNext;
                        if (countNext == OVERSIZE_T) begin
                            state <= OVERSIZE;
                        end
                    end else begin
                        state <= CLASSIFY;
                    end
                end
                CLASSIFY: begin
                    if (longEnough) begin
                        if (matchFound) begin
                            coin_valid <= 1'b1;
                            coin_id    <= matchId;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                    // A new coin may already be blocking the sensor; keep its first cycle.
                    if (sensorS) begin
                        state <= MEASURE;
                        count <= TIME_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                OVERSIZE: begin
                    if (!sensorS) begin
                        coin_reject <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COIN_CREDIT_EN
    localparam int SUM_W = ((CREDIT_W > 8) ? CREDIT_W : 8) + 1;
    localparam logic [SUM_W-1:0] CREDIT_MAX = {{(SUM_W-CREDIT_W){1'b0}}, {CREDIT_W{1'b1}}};

    logic             addEvent;
    logic [7:0]       addVal;
    logic [SUM_W-1:0] creditSum;

    assign addEvent  = (state == CLASSIFY) && longEnough && matchFound;
    assign addVal    = COIN_VALUES[int'(matchId)*8 +: 8];
    assign creditSum = SUM_W'(credit) + SUM_W'(addVal);

    always_ff @(posedge clk) begin
        if (reset || clear_credit) begin
            credit <= '0;
        end else if (addEvent) begin
            credit <= (creditSum > CREDIT_MAX) ? {CREDIT_W{1'b1}} : creditSum[CREDIT_W-1:0];
        end
    end
`else
    logic unusedCredit;
    assign unusedCredit = &{1'b0, clear_credit, COIN_VALUES};
    assign credit       = '0;
`endif

endmodule

// File: tb/tb_coin_classifier.sv
// Scoreboard bench for coin_classifier: random and directed sensor pulses, expected events
// from a duration-rule model, checked by a separate output monitor.
module tb_coin_classifier;

    localparam int SYNC = 2;
    localparam int OVER = 40;
    localparam int MINP = 3;
`ifdef COIN_CREDIT_EN
    localparam bit CREDIT_EN = 1'b1;
`else
    localparam bit CREDIT_EN = 1'b0;
`endif

    typedef struct {
        int kind;   // 0 = coin_valid, 1 = coin_reject
        int id;
        int cyc;
        int cred;
        int cred6;
    } expEvent_t;

    logic        clk;
    logic        reset;
    logic        coinSensor;
    logic        clearCredit;
    logic        coinValid, coinReject, busy;
    logic [1:0]  coinId;
    logic [15:0] credit;
    logic        coinValid6, coinReject6, busy6;
    logic [1:0]  coinId6;
    logic [5:0]  credit6;

    int minT[3] = '{10, 20, 30};
    int maxT[3] = '{12, 22, 32};
    int vals[3] = '{10, 5, 25};

    expEvent_t expQ[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busyCycles = 0;
    int modelCredit = 0;
    int modelCredit6 = 0;

    coin_classifier #(
        .NUM_COINS(3), .TIME_W(8), .SYNC_STAGES(SYNC),
        .MIN_TIMES({8'd30, 8'd20, 8'd10}), .MAX_TIMES({8'd32, 8'd22, 8'd12}),
        .MIN_PULSE(MINP), .OVERSIZE_LIMIT(OVER), .CREDIT_W(16),
        .COIN_VALUES({8'd25, 8'd5, 8'd10})
    ) dut (
        .clk(clk), .reset(reset), .coin_sensor(coinSensor), .clear_credit(clearCredit),
        .coin_valid(coinValid), .coin_id(coinId), .coin_reject(coinReject),
        .busy(busy), .credit(credit)
    );

    coin_classifier #(
        .NUM_COINS(3), .TIME_W(8), .SYNC_STAGES(SYNC),
        .MIN_TIMES({8'd30, 8'd20, 8'd10}), .MAX_TIMES({8'd32, 8'd22, 8'd12}),
        .MIN_PULSE(MINP), .OVERSIZE_LIMIT(OVER), .CREDIT_W(6),
        .COIN_VALUES({8'd25, 8'd5, 8'd10})
    ) dut6 (
        .clk(clk), .reset(reset), .coin_sensor(coinSensor), .clear_credit(clearCredit),
        .coin_valid(coinValid6), .coin_id(coinId6), .coin_reject(coinReject6),
        .busy(busy6), .credit(credit6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expected event per output pulse.
    always @(negedge clk) begin
        if (busy) busyCycles++;
        if (!reset && (coinValid || coinReject)) begin
            check("valid_reject_exclusive", int'(coinValid && coinReject), 0);
            if (expQ.size() == 0) begin
                check("unexpected_pulse", int'(coinValid) * 10 + int'(coinReject), 0);
            end else begin
                expEvent_t e;
                e = expQ.pop_front();
                check("pulse_kind", coinReject ? 1 : 0, e.kind);
                if (e.kind == 0) check("coin_id", int'(coinId), e.id);
                check("pulse_latency", cyc, e.cyc);
                check("credit", int'(credit), e.cred);
                check("credit6", int'(credit6), e.cred6);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int satAdd(input int a, input int b, input int maxV);
        return (a + b > maxV) ? maxV : a + b;
    endfunction

    // Duration rules: oversize, glitch, first matching window, else reject.
    task automatic predict(input int h, output int kind, output int id, output int lat);
        kind = -1;
        id   = 0;
        lat  = SYNC + 2;
        if (h >= OVER) begin
            kind = 1;
            lat  = SYNC + 1;
        end else if (h >= MINP) begin
            kind = 1;
            for (int i = 2; i >= 0; i--) begin
                if (h >= minT[i] && h <= maxT[i]) begin
                    kind = 0;
                    id   = i;
                end
            end
        end
    endtask

    task automatic coin(input int h, input int gap, input bit clrWithAdd);
        int kind, id, lat;
        expEvent_t e;
        predict(h, kind, id, lat);
        coinSensor = 1'b1;
        repeat (h) tick();
        coinSensor = 1'b0;
        if (kind == 0) begin
            if (clrWithAdd) begin
                modelCredit  = 0;
                modelCredit6 = 0;
            end else begin
                modelCredit  = satAdd(modelCredit, vals[id], 65535);
                modelCredit6 = satAdd(modelCredit6, vals[id], 63);
            end
        end
        if (kind >= 0) begin
            e.kind  = kind;
            e.id    = id;
            e.cyc   = cyc + lat;
            e.cred  = CREDIT_EN ? modelCredit : 0;
            e.cred6 = CREDIT_EN ? modelCredit6 : 0;
            expQ.push_back(e);
        end
        if (clrWithAdd) begin
            // Clear sampled on the same edge that registers coin_valid.
            repeat (SYNC + 1) tick();
            clearCredit = 1'b1;
            tick();
            clearCredit = 1'b0;
            repeat (gap - SYNC - 2) tick();
        end else begin
            repeat (gap) tick();
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_coin_valid"}, int'(coinValid), 0);
        check({tag, "_coin_reject"}, int'(coinReject), 0);
        check({tag, "_coin_id"}, int'(coinId), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_credit"}, int'(credit), 0);
        check({tag, "_credit6"}, int'(credit6), 0);
    endtask

    int edgeH[10] = '{9, 10, 12, 13, 19, 20, 22, 30, 32, 33};

    initial begin
        int b0;
        reset       = 1'b1;
        coinSensor  = 1'b0;
        clearCredit = 1'b0;
        repeat (3) tick();
        checkIdleOutputs("reset");
        reset = 1'b0;
        tick();

        coin(11, 8, 1'b0);
        coin(20, 8, 1'b0);
        coin(32, 8, 1'b0);
        coin(19, 8, 1'b0);
        coin(33, 8, 1'b0);

        b0 = busyCycles;
        coin(2, 8, 1'b0);
        check("busy_glitch_cycles", busyCycles - b0, 3);
        check("busy_after_glitch", int'(busy), 0);

        b0 = busyCycles;
        coin(60, 8, 1'b0);
        check("busy_oversize_cycles", busyCycles - b0, 60);
        coin(39, 8, 1'b0);
        coin(40, 8, 1'b0);

        coin(15, 1, 1'b0);
        coin(11, 8, 1'b0);

        coin(32, 8, 1'b0);
        coinSensor = 1'b1;
        repeat (10) tick();
        coinSensor = 1'b0;
        reset      = 1'b1;
        repeat (2) tick();
        checkIdleOutputs("mid_reset");
        modelCredit  = 0;
        modelCredit6 = 0;
        reset = 1'b0;
        tick();
        coin(21, 8, 1'b0);

        clearCredit = 1'b1;
        tick();
        clearCredit  = 1'b0;
        modelCredit  = 0;
        modelCredit6 = 0;
        check("idle_clear_credit", int'(credit), 0);
        repeat (5) coin(32, 6, 1'b0);
        coin(11, 10, 1'b1);

        for (int n = 0; n < 40; n++) begin
            int h;
            if ($urandom_range(0, 2) == 0) h = edgeH[$urandom_range(0, 9)];
            else h = $urandom_range(1, 45);
            coin(h, $urandom_range(1, 6), 1'b0);
        end

        repeat (12) tick();
        check("scoreboard_drained", expQ.size(), 0);
        check("final_credit", int'(credit), CREDIT_EN ? modelCredit : 0);
        check("final_credit6", int'(credit6), CREDIT_EN ? modelCredit6 : 0);
        check("final_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
